// File: rtl/ps2_cmd_arbiter.sv
// rtl/ps2_cmd_arbiter.sv - round-robin arbiter sharing the PS/2 send/receive engines among command requesters.
// Optional statistics outputs (retry_cnt, err_cnt) are built only when PS2_ARB_STATS_EN is defined.
module ps2_cmd_arbiter #(
    parameter int NREQ        = 3,
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 20000,
    parameter int TO_W        = 16
) (
    input  logic              qzt_clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_byte,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_done,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rx_fwd_valid,
    output logic              busy
`ifdef PS2_ARB_STATS_EN
    ,
    output logic [7:0]        retry_cnt,
    output logic [7:0]        err_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;
    localparam logic [7:0] RESP_ERROR  = 8'hFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TO_W-1:0] to_q, to_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            ack_ev, nack_ev, fail_ev, can_retry, retry_ev, give_up;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        logic [IW:0] s;
        s = {1'b0, base} + (IW+1)'(off);
        if (s >= (IW+1)'(NREQ)) begin
            s = s - (IW+1)'(NREQ);
        end
        return s[IW-1:0];
    endfunction

    // Scan from the highest offset down so the nearest requester at/after rr_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[wrap_add(rr_q, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(rr_q, i);
            end
        end
    end

    // Response decode; a received byte always takes precedence over the timeout.
    always_comb begin
        ack_ev    = (state_q == S_WAIT_ACK) && rx_valid && (rx_byte == RESP_ACK);
        fail_ev   = (state_q == S_WAIT_ACK) && rx_valid && (rx_byte == RESP_ERROR);
        nack_ev   = (state_q == S_WAIT_ACK) &&
                    ((rx_valid && (rx_byte == RESP_RESEND)) ||
                     (!rx_valid && (to_q == TO_W'(ACK_TIMEOUT - 1))));
        can_retry = (retry_q < RW'(MAX_RETRY));
        retry_ev  = nack_ev && can_retry;
        give_up   = fail_ev || (nack_ev && !can_retry);
    end

    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            tx_byte_q <= 8'h00;
            retry_q   <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            tx_byte_q <= tx_byte_d;
            retry_q   <= retry_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        tx_byte_d = tx_byte_q;
        retry_d   = retry_q;
        to_d      = to_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d   = NREQ'(1) << pick_idx;
                    gidx_d    = pick_idx;
                    tx_byte_d = req_byte[{pick_idx, 3'b000} +: 8];
                    retry_d   = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    to_d    = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                to_d = to_q + TO_W'(1);
                if (ack_ev || give_up) begin
                    grant_d = '0;
                    state_d = S_RELEASE;
                end else if (retry_ev) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_SEND;
                end
            end
            S_RELEASE: begin
                rr_d    = wrap_add(gidx_q, 1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        grant        = grant_q;
        tx_byte      = tx_byte_q;
        busy         = (state_q != S_IDLE);
        tx_start     = (state_q == S_SEND);
        done         = ack_ev  ? grant_q : '0;
        err          = give_up ? grant_q : '0;
        rx_fwd_valid = !rst && (state_q == S_IDLE) && !(|req) && rx_valid;
    end

`ifdef PS2_ARB_STATS_EN
    logic [7:0] retry_cnt_q, err_cnt_q;

    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            retry_cnt_q <= 8'h00;
            err_cnt_q   <= 8'h00;
        end else begin
            if (retry_ev && (retry_cnt_q != 8'hFF)) begin
                retry_cnt_q <= retry_cnt_q + 8'd1;
            end
            if (give_up && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign retry_cnt = retry_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// tb/tb_ps2_cmd_arbiter.sv - scoreboard bench for ps2_cmd_arbiter with a send/receive engine stub.
module tb_ps2_cmd_arbiter;

    localparam int NREQ        = 3;
    localparam int MAX_RETRY   = 3;
    localparam int ACK_TIMEOUT = 60;
    localparam int TO_W        = 8;
    localparam int NATT        = MAX_RETRY + 1;

    localparam int R_NONE   = 0;
    localparam int R_ACK    = 1;
    localparam int R_RESEND = 2;
    localparam int R_FAIL   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_byte;
    logic [NREQ-1:0]   grant, done, err;
    logic [7:0]        tx_byte;
    logic              tx_start;
    logic              tx_done;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_fwd_valid;
    logic              busy;
`ifdef PS2_ARB_STATS_EN
    logic [7:0]        retry_cnt, err_cnt;
`endif

    ps2_cmd_arbiter #(
        .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .qzt_clk(clk), .rst(rst), .req(req), .req_byte(req_byte),
        .grant(grant), .done(done), .err(err),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_done(tx_done),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_fwd_valid(rx_fwd_valid), .busy(busy)
`ifdef PS2_ARB_STATS_EN
        , .retry_cnt(retry_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [7:0] b;
        bit         is_err;
        int         ntx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fwd_q[$];

    int scr[NREQ][NATT];
    int tx_dly[NREQ];
    int rx_dly[NREQ];
    bit junk[NREQ];

    int n_pass = 0;
    int n_total = 0;
    int rr_m = 0;
    int m_retry = 0;
    int m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [7:0] code_byte(input int code);
        case (code)
            R_ACK:    return 8'hFA;
            R_RESEND: return 8'hFE;
            default:  return 8'hFC;
        endcase
    endfunction

    // Reference outcome: walk the attempts until ACK, hard error, or the retry budget runs out.
    task automatic predict_push(input int i);
        exp_t e;
        e.idx = i; e.b = req_byte[8*i +: 8]; e.is_err = 1'b0; e.ntx = 0;
        for (int k = 0; k < NATT; k++) begin
            e.ntx = k + 1;
            if (scr[i][k] == R_ACK) break;
            if (scr[i][k] == R_FAIL || k == MAX_RETRY) begin
                e.is_err = 1'b1;
                break;
            end
        end
        m_retry += e.ntx - 1;
        if (e.is_err) m_err++;
        exp_q.push_back(e);
    endtask

    task automatic stub_loop();
        int g, att, last_done, code;
        bit last_none;
        logic [7:0] jb;
        att = 0; last_done = 0; last_none = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                att = 0;
                last_none = 1'b0;
            end
            while (!rst && tx_start) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (grant[i]) g = i;
                if (last_none) chk("timeout_gap", cyc - last_done, ACK_TIMEOUT + 1);
                for (int k = 1; k < tx_dly[g]; k++) begin
                    @(negedge clk);
                    if (junk[g] && k == 1) begin
                        rx_byte = 8'($urandom);
                        rx_valid = 1'b1;
                    end else rx_valid = 1'b0;
                end
                @(negedge clk);
                rx_valid = 1'b0;
                tx_done = 1'b1;
                last_done = cyc;
                @(negedge clk);
                tx_done = 1'b0;
                code = scr[g][att];
                att++;
                last_none = (code == R_NONE);
                if (code != R_NONE) begin
                    for (int k = 1; k < rx_dly[g]; k++) begin
                        if (k > 1) @(negedge clk);
                        if (junk[g] && k == 1) begin
                            jb = 8'($urandom);
                            if (jb == 8'hFA || jb == 8'hFE || jb == 8'hFC) jb = 8'h08;
                            rx_byte = jb;
                            rx_valid = 1'b1;
                        end else rx_valid = 1'b0;
                    end
                    @(negedge clk);
                    rx_byte = code_byte(code);
                    rx_valid = 1'b1;
                    @(negedge clk);
                    rx_valid = 1'b0;
                end
                if (code == R_ACK || code == R_FAIL || att == NATT) begin
                    att = 0;
                    last_none = 1'b0;
                end
            end
        end
    endtask

    // Samples one time unit before the active edge, after all input changes settle.
    task automatic mon_loop();
        int ntx;
        exp_t e;
        logic [7:0] fb;
        ntx = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                ntx = 0;
                continue;
            end
            if (grant != '0) chk("grant_onehot", 32'($onehot(grant)), 1);
            if (tx_start) begin
                if (exp_q.size() == 0) chk("tx_start_unexpected", 1, 0);
                else begin
                    chk("tx_byte", tx_byte, exp_q[0].b);
                    chk("tx_grant", grant, 1 << exp_q[0].idx);
                end
                ntx++;
            end
            if ((done | err) != '0) begin
                if (exp_q.size() == 0) chk("resp_unexpected", done | err, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done", done, e.is_err ? 0 : (1 << e.idx));
                    chk("err", err, e.is_err ? (1 << e.idx) : 0);
                    chk("tx_count", ntx, e.ntx);
                    chk("resp_grant", grant, 1 << e.idx);
                end
                req = req & ~(done | err);
                ntx = 0;
            end
            if (rx_fwd_valid) begin
                if (fwd_q.size() == 0) chk("fwd_unexpected", 1, 0);
                else begin
                    fb = fwd_q.pop_front();
                    chk("fwd_byte", rx_byte, fb);
                end
            end
        end
    endtask

    task automatic finish_now();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    task automatic run_round(input logic [NREQ-1:0] mask);
        int last, k;
        last = rr_m;
        for (int off = 0; off < NREQ; off++) begin
            if (mask[(rr_m + off) % NREQ]) begin
                predict_push((rr_m + off) % NREQ);
                last = (rr_m + off) % NREQ;
            end
        end
        rr_m = (last + 1) % NREQ;
        @(negedge clk);
        req = mask;
        for (k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (req == '0 && !busy) break;
        end
        chk("round_complete", (req == '0 && !busy), 1);
        if (k == 4000) finish_now();
    endtask

    task automatic idle_fwd(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_valid = 1'b1;
        fwd_q.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] b, input int c0, input int c1,
                           input int c2, input int c3, input int td, input int rd, input bit j);
        req_byte[8*i +: 8] = b;
        scr[i][0] = c0; scr[i][1] = c1; scr[i][2] = c2; scr[i][3] = c3;
        tx_dly[i] = td; rx_dly[i] = rd; junk[i] = j;
    endtask

    function automatic int rand_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45) return R_ACK;
        if (r < 70) return R_RESEND;
        if (r < 80) return R_FAIL;
        return R_NONE;
    endfunction

    initial begin
        rst = 1'b1; req = '0; req_byte = '0; tx_done = 1'b0; rx_byte = 8'h08; rx_valid = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h00, R_ACK, R_ACK, R_ACK, R_ACK, 4, 4, 1'b0);
        fork
            mon_loop();
            stub_loop();
        join_none
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fwd", rx_fwd_valid, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        set_req(0, 8'hF4, R_ACK, R_ACK, R_ACK, R_ACK, 100, 50, 1'b0);
        run_round(3'b001);
        idle_fwd(8'h08);
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + 8'(i), R_ACK, R_ACK, R_ACK, R_ACK, 5, 5, 1'b0);
        run_round(3'b111);
        run_round(3'b111);
        set_req(1, 8'hE8, R_RESEND, R_RESEND, R_ACK, R_ACK, 6, 8, 1'b1);
        run_round(3'b010);
        set_req(0, 8'hF3, R_NONE, R_NONE, R_NONE, R_NONE, 7, 4, 1'b1);
        run_round(3'b001);
        set_req(2, 8'hFF, R_FAIL, R_ACK, R_ACK, R_ACK, 4, 6, 1'b1);
        run_round(3'b100);
        idle_fwd(8'h3C);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 8'($urandom), rand_code(), rand_code(), rand_code(), rand_code(),
                        $urandom_range(3, 12), $urandom_range(3, 40), 1'($urandom));
            run_round(3'($urandom_range(1, 7)));
            if ($urandom_range(0, 1) == 1) idle_fwd(8'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("fwd_q_drained", fwd_q.size(), 0);
`ifdef PS2_ARB_STATS_EN
        chk("retry_cnt", retry_cnt, (m_retry > 255) ? 255 : m_retry);
        chk("err_cnt", err_cnt, (m_err > 255) ? 255 : m_err);
`endif

        // Asynchronous reset while waiting for the response.
        set_req(0, 8'hAA, R_NONE, R_NONE, R_NONE, R_NONE, 4, 4, 1'b0);
        set_req(1, 8'hBB, R_ACK, R_ACK, R_ACK, R_ACK, 4, 4, 1'b0);
        set_req(2, 8'hCC, R_ACK, R_ACK, R_ACK, R_ACK, 4, 4, 1'b0);
        predict_push(0);
        @(negedge clk);
        req = 3'b001;
        repeat (15) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_tx_start", tx_start, 0);
        exp_q.delete();
        req = 3'b111;
        repeat (2) @(negedge clk);
        rr_m = 0;
        predict_push(0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_grant", grant, 3'b001);
        chk("post_rst_tx_start", tx_start, 1);
        repeat (2) @(negedge clk);
        finish_now();
    end

endmodule

// File: doc/ps2_cmd_arbiter.md
Name: ps2_cmd_arbiter

Overview:
- Owns the PS/2 host-to-device path. Shares one byte-level send engine and one receive engine among NREQ command requesters (init sequencer, resend logic, user commands).
- Arbitrates round-robin, launches one command byte, waits for the mouse response byte, retries on resend or timeout, and reports done or error per requester.
- Outside a transaction, received bytes go to the stream decoder.

Parameters:
- NREQ, 3, number of requesters; 2..8.
- MAX_RETRY, 3, retransmissions after the first attempt before declaring an error.
- ACK_TIMEOUT, 20000, qzt_clk cycles to wait for a response after tx_done.
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- qzt_clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester level request; held until done or err.
- req_byte  in  8*NREQ  command byte; requester i uses bits [8i+7:8i]; stable while req[i] is high.
- grant  out  NREQ  one-hot; high for the whole transaction of the served requester.
- done  out  NREQ  1-cycle pulse; response 0xFA (ACK) received.
- err  out  NREQ  1-cycle pulse; 0xFC received, or retries exhausted.
- tx_byte  out  8  byte to the send engine; stable from tx_start until tx_done.
- tx_start  out  1  1-cycle pulse that starts the send engine.
- tx_done  in  1  1-cycle pulse from the send engine; frame sent.
- rx_byte  in  8  byte from the receive engine, parity already stripped.
- rx_valid  in  1  1-cycle pulse; rx_byte is valid.
- rx_fwd_valid  out  1  1-cycle pulse; rx_byte forwarded to the stream decoder.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state IDLE; grant, done, err, tx_start, rx_fwd_valid, busy = 0; tx_byte = 0x00; RR pointer = 0; retry and timeout counters = 0.

FSM states:
- IDLE:
  - If any req bit is high, pick the first requester at or after the RR pointer (wrapping modulo NREQ).
  - Register its grant bit and latch its req_byte into tx_byte; retry counter = 0; go to SEND.
  - If no req is high, each rx_valid pulse produces rx_fwd_valid in the same cycle (combinational pass-through, gated on IDLE).
- SEND: assert tx_start for exactly 1 cycle; go to WAIT_TX.
- WAIT_TX: on tx_done, clear the timeout counter and go to WAIT_ACK. rx_valid in this state is dropped (not forwarded).
- WAIT_ACK: timeout counter increments every cycle. On rx_valid:
  - 0xFA: done[g] pulse, go to RELEASE.
  - 0xFE: if retry < MAX_RETRY, retry+1 and go to SEND; otherwise err[g] pulse, go to RELEASE.
  - 0xFC: err[g] pulse immediately (no retry), go to RELEASE.
  - Any other byte: ignored; the counter keeps running.
  - Timeout (counter == ACK_TIMEOUT-1 with no rx_valid): handled the same way as 0xFE.
  - rx_valid and timeout in the same cycle: rx_valid wins.
- RELEASE: grant = 0; RR pointer = g+1 mod NREQ; go to IDLE. One dead cycle, so a requester dropping req after done is never regranted.

Latency and arbitration rules:
- Minimum latency req to tx_start: 2 cycles (IDLE registers grant, SEND pulses).
- done/err pulses coincide with the cycle the FSM leaves WAIT_ACK; grant is still high in that cycle.
- req[g] dropping mid-transaction does not abort; the transaction completes and its done/err is still issued.
- req changes on non-granted lines are ignored until IDLE.
- Exactly one grant bit, or none, is high at any time. done|err pulses at most once per grant.

Optional Feature:
- Macro: PS2_ARB_STATS_EN.
- With the macro defined:
  - Extra output retry_cnt [7:0]: saturating count of retransmissions since reset (0xFE and timeouts).
  - Extra output err_cnt [7:0]: saturating count of err pulses.
  - Both reset to 0 and stick at 0xFF.
- Without the macro: ports and counters are absent; core behaviour is identical.

Test Plan:
- req=3'b001, byte 0xF4; stub sends the frame, tx_done after 100 cycles, rx 0xFA after 50 more -> tx_start once with tx_byte=0xF4; done[0] pulse; grant back to 0; busy low 1 cycle later.
- req=3'b111 held, all answered 0xFA -> grant order 0,1,2,0; no cycle with two grant bits set.
- Requester 1 sends 0xE8; stub answers 0xFE twice, then 0xFA -> three tx_start pulses, all 0xE8; done[1]; retry_cnt=2 when STATS enabled.
- No response, ACK_TIMEOUT=20000 -> four tx_start pulses, 20000 cycles apart after each tx_done; err[0] pulse; err_cnt=1.
- Stub answers 0xFC -> err pulse with no retransmission. rx_valid 0x08 while IDLE -> rx_fwd_valid pulse. rx_valid during WAIT_TX -> no forward.
- rst asserted during WAIT_ACK, asynchronously -> grant, busy, tx_start = 0 immediately; after release the next req is granted to requester 0.
